// File: rtl/rgb2ycbcr_pipe.sv
// rgb2ycbcr_pipe: 3-stage pipelined RGB to YCbCr converter (BT.601 full-range, 8-bit).
//
// Ports:
//   clk, rst_n                  pixel clock, asynchronous active-low reset
//   per_frame_vsync/href/clken  input frame syncs and pixel-valid strobe
//   per_rgb[23:0]               {R8,G8,B8}, or {R5,G6,B5} on [15:0] when RGB565_MODE=1
//   post_frame_vsync/href/clken syncs delayed by SYNC_LATENCY clocks
//   post_y/post_cb/post_cr      converted pixel, aligned with the delayed syncs
//
// The data path is free-running; it advances every clock whatever the value of
// per_frame_clken, so results while post_frame_clken=0 are meaningless but deterministic.
module rgb2ycbcr_pipe #(
  parameter bit          RGB565_MODE  = 1'b1,
  // Documents the fixed pipeline depth; the data path is hard-wired to 3 stages.
  parameter int unsigned SYNC_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [23:0] per_rgb,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic [7:0]  post_y,
  output logic [7:0]  post_cb,
  output logic [7:0]  post_cr
);

  logic [7:0] r8, g8, b8;
  logic       unused_rgb_hi;

  // RGB565 is widened by replicating the MSBs into the vacated LSBs so that
  // full-scale 5/6-bit codes map onto 255.
  always_comb begin
    if (RGB565_MODE) begin
      r8 = {per_rgb[15:11], per_rgb[15:13]};
      g8 = {per_rgb[10:5],  per_rgb[10:9]};
      b8 = {per_rgb[4:0],   per_rgb[4:2]};
    end else begin
      r8 = per_rgb[23:16];
      g8 = per_rgb[15:8];
      b8 = per_rgb[7:0];
    end
  end

  assign unused_rgb_hi = ^per_rgb[23:16];

  // Stage 1: coefficient products.
  logic [15:0] p_yr_q, p_yg_q, p_yb_q;
  logic [15:0] p_cbr_q, p_cbg_q, p_cbb_q;
  logic [15:0] p_crr_q, p_crg_q, p_crb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_yr_q  <= '0;
      p_yg_q  <= '0;
      p_yb_q  <= '0;
      p_cbr_q <= '0;
      p_cbg_q <= '0;
      p_cbb_q <= '0;
      p_crr_q <= '0;
      p_crg_q <= '0;
      p_crb_q <= '0;
    end else begin
      p_yr_q  <= 16'd77  * {8'd0, r8};
      p_yg_q  <= 16'd150 * {8'd0, g8};
      p_yb_q  <= 16'd29  * {8'd0, b8};
      p_cbr_q <= 16'd43  * {8'd0, r8};
      p_cbg_q <= 16'd85  * {8'd0, g8};
      p_cbb_q <= 16'd128 * {8'd0, b8};
      p_crr_q <= 16'd128 * {8'd0, r8};
      p_crg_q <= 16'd107 * {8'd0, g8};
      p_crb_q <= 16'd21  * {8'd0, b8};
    end
  end

  // Stage 2: signed sums. 128 rounds the >>8; 32896 adds the chroma offset too.
  logic signed [17:0] y_sum_d, cb_sum_d, cr_sum_d;
  logic signed [17:0] y_sum_q, cb_sum_q, cr_sum_q;

  always_comb begin
    y_sum_d  = signed'(18'(p_yr_q) + 18'(p_yg_q) + 18'(p_yb_q) + 18'd128);
    cb_sum_d = signed'(18'(p_cbb_q) - 18'(p_cbr_q) - 18'(p_cbg_q) + 18'd32896);
    cr_sum_d = signed'(18'(p_crr_q) - 18'(p_crg_q) - 18'(p_crb_q) + 18'd32896);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_sum_q  <= '0;
      cb_sum_q <= '0;
      cr_sum_q <= '0;
    end else begin
      y_sum_q  <= y_sum_d;
      cb_sum_q <= cb_sum_d;
      cr_sum_q <= cr_sum_d;
    end
  end

  // Stage 3: scale down and clamp to 0..255. Negative sums cannot occur for
  // legal pixels but are still clamped.
  function automatic logic [7:0] sat8(input logic signed [17:0] sum);
    logic signed [17:0] sh;
    sh = sum >>> 8;
    if (sh < 18'sd0) begin
      return 8'd0;
    end else if (sh > 18'sd255) begin
      return 8'd255;
    end else begin
      return sh[7:0];
    end
  endfunction

  logic [7:0] y_q, cb_q, cr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q  <= '0;
      cb_q <= '0;
      cr_q <= '0;
    end else begin
      y_q  <= sat8(y_sum_q);
      cb_q <= sat8(cb_sum_q);
      cr_q <= sat8(cr_sum_q);
    end
  end

  // Sync delay lines, unconditional so edges stay cycle-aligned with the data.
  logic [SYNC_LATENCY-1:0] vsync_q, href_q, clken_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= '0;
      href_q  <= '0;
      clken_q <= '0;
    end else begin
      vsync_q <= {vsync_q[SYNC_LATENCY-2:0], per_frame_vsync};
      href_q  <= {href_q[SYNC_LATENCY-2:0],  per_frame_href};
      clken_q <= {clken_q[SYNC_LATENCY-2:0], per_frame_clken};
    end
  end

  assign post_frame_vsync = vsync_q[SYNC_LATENCY-1];
  assign post_frame_href  = href_q[SYNC_LATENCY-1];
  assign post_frame_clken = clken_q[SYNC_LATENCY-1];
  assign post_y           = y_q;
  assign post_cb          = cb_q;
  assign post_cr          = cr_q;

endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
// Testbench for rgb2ycbcr_pipe: one RGB565 and one RGB888 instance share the same
// stimulus; a queue of presented pixels provides the 3-edge-delayed expectations.
module tb_rgb2ycbcr_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs, hr, ce;
  logic [23:0] rgb;

  logic       vs_a, hr_a, ce_a, vs_b, hr_b, ce_b;
  logic [7:0] y_a, cb_a, cr_a, y_b, cb_b, cr_b;

  always #5 clk = ~clk;

  rgb2ycbcr_pipe #(.RGB565_MODE(1'b1), .SYNC_LATENCY(3)) dut565 (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (vs),
    .per_frame_href   (hr),
    .per_frame_clken  (ce),
    .per_rgb          (rgb),
    .post_frame_vsync (vs_a),
    .post_frame_href  (hr_a),
    .post_frame_clken (ce_a),
    .post_y           (y_a),
    .post_cb          (cb_a),
    .post_cr          (cr_a)
  );

  rgb2ycbcr_pipe #(.RGB565_MODE(1'b0), .SYNC_LATENCY(3)) dut888 (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (vs),
    .per_frame_href   (hr),
    .per_frame_clken  (ce),
    .per_rgb          (rgb),
    .post_frame_vsync (vs_b),
    .post_frame_href  (hr_b),
    .post_frame_clken (ce_b),
    .post_y           (y_b),
    .post_cb          (cb_b),
    .post_cr          (cr_b)
  );

  typedef struct {
    logic [23:0] rgb;
    logic        vs, hr, ce;
    bit          has_k565, has_k888;
    logic [23:0] k565, k888;
  } stim_t;

  stim_t q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int clamp8(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  // Reference conversion straight from the BT.601 integer formulas.
  function automatic logic [23:0] ref_ycc(input logic [23:0] px, input bit m565);
    int r, g, b, y, cb, cr;
    if (m565) begin
      r = (int'(px[15:11]) << 3) | (int'(px[15:11]) >> 2);
      g = (int'(px[10:5])  << 2) | (int'(px[10:5])  >> 4);
      b = (int'(px[4:0])   << 3) | (int'(px[4:0])   >> 2);
    end else begin
      r = int'(px[23:16]);
      g = int'(px[15:8]);
      b = int'(px[7:0]);
    end
    y  = clamp8((77 * r + 150 * g + 29 * b + 128) >>> 8);
    cb = clamp8((128 * b - 43 * r - 85 * g + 32896) >>> 8);
    cr = clamp8((128 * r - 107 * g - 21 * b + 32896) >>> 8);
    return {8'(y), 8'(cb), 8'(cr)};
  endfunction

  function automatic stim_t mk(input logic [23:0] px, input logic v, input logic h,
                               input logic c);
    stim_t s;
    s.rgb = px; s.vs = v; s.hr = h; s.ce = c;
    s.has_k565 = 1'b0; s.has_k888 = 1'b0; s.k565 = '0; s.k888 = '0;
    return s;
  endfunction

  // Present one pixel across one rising edge, then check what emerged.
  task automatic drive_cycle(input stim_t s);
    stim_t e;
    rgb = s.rgb; vs = s.vs; hr = s.hr; ce = s.ce;
    @(posedge clk);
    #1;
    q.push_back(s);
    if (q.size() < 3) begin
      // Pipeline still refilling after reset: nothing may be emitted yet.
      check_eq("fill565", {29'd0, vs_a, hr_a, ce_a}, 32'd0);
      check_eq("fill888", {29'd0, vs_b, hr_b, ce_b}, 32'd0);
      check_eq("fill_y", {16'd0, y_a, y_b}, 32'd0);
    end else begin
      e = q.pop_front();
      check_eq("sync565", {29'd0, vs_a, hr_a, ce_a}, {29'd0, e.vs, e.hr, e.ce});
      check_eq("sync888", {29'd0, vs_b, hr_b, ce_b}, {29'd0, e.vs, e.hr, e.ce});
      check_eq("ycc565", {8'd0, y_a, cb_a, cr_a}, {8'd0, ref_ycc(e.rgb, 1'b1)});
      check_eq("ycc888", {8'd0, y_b, cb_b, cr_b}, {8'd0, ref_ycc(e.rgb, 1'b0)});
      if (e.has_k565) check_eq("const565", {8'd0, y_a, cb_a, cr_a}, {8'd0, e.k565});
      if (e.has_k888) check_eq("const888", {8'd0, y_b, cb_b, cr_b}, {8'd0, e.k888});
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {5'd0, vs_a, hr_a, ce_a, y_a, cb_a, cr_a}, 32'd0);
    check_eq(tag, {5'd0, vs_b, hr_b, ce_b, y_b, cb_b, cr_b}, 32'd0);
  endtask

  logic [23:0] prim_rgb [5];
  logic [23:0] prim_exp [5];
  logic [15:0] p565_rgb [4];
  logic [23:0] p565_exp [4];
  logic [7:0]  ce_pat;

  initial begin
    stim_t s;
    prim_rgb = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF};
    prim_exp = '{{8'd255, 8'd128, 8'd128}, {8'd0, 8'd128, 8'd128},
                 {8'd77, 8'd85, 8'd255}, {8'd149, 8'd43, 8'd21},
                 {8'd29, 8'd255, 8'd107}};
    p565_rgb = '{16'hFFFF, 16'hF800, 16'h001F, 16'h07E0};
    p565_exp = '{{8'd255, 8'd128, 8'd128}, {8'd77, 8'd85, 8'd255},
                 {8'd29, 8'd255, 8'd107}, {8'd149, 8'd43, 8'd21}};
    ce_pat   = 8'b11001101; // LSB first: 1,0,1,1,0,0,1,1

    // Reset held with a live white pixel on the inputs.
    rst_n = 1'b0; vs = 1'b0; hr = 1'b1; ce = 1'b1; rgb = 24'hFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    q.delete();
    s = mk(24'hFFFFFF, 1'b0, 1'b1, 1'b1);
    s.has_k888 = 1'b1; s.k888 = {8'd255, 8'd128, 8'd128};
    repeat (3) drive_cycle(s);

    // RGB888 primaries back to back.
    for (int i = 0; i < 5; i++) begin
      s = mk(prim_rgb[i], 1'b0, 1'b1, 1'b1);
      s.has_k888 = 1'b1; s.k888 = prim_exp[i];
      drive_cycle(s);
    end

    // RGB565 primaries with junk in the unused upper byte.
    for (int i = 0; i < 4; i++) begin
      s = mk({8'($urandom), p565_rgb[i]}, 1'b0, 1'b1, 1'b1);
      s.has_k565 = 1'b1; s.k565 = p565_exp[i];
      drive_cycle(s);
    end

    // Sync alignment: vsync pulse, then an 8-pixel href window.
    drive_cycle(mk(24'($urandom), 1'b0, 1'b0, 1'b0));
    drive_cycle(mk(24'($urandom), 1'b1, 1'b0, 1'b0));
    drive_cycle(mk(24'($urandom), 1'b1, 1'b0, 1'b0));
    drive_cycle(mk(24'($urandom), 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++) drive_cycle(mk(24'($urandom), 1'b0, 1'b1, ce_pat[i]));
    repeat (4) drive_cycle(mk(24'($urandom), 1'b0, 1'b0, 1'b0));

    // Mid-frame asynchronous reset between edges.
    repeat (6) drive_cycle(mk(24'($urandom), 1'b0, 1'b1, 1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    rst_n = 1'b1;
    q.delete();
    repeat (6) drive_cycle(mk(24'($urandom), 1'b0, 1'b1, 1'b1));

    // Random regression.
    for (int i = 0; i < 10000; i++) begin
      drive_cycle(mk(24'($urandom), 1'($urandom_range(0, 15) == 0), 1'($urandom),
                     1'($urandom)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rgb2ycbcr_pipe.md
Name: rgb2ycbcr_pipe

Overview:
- Pipelined RGB-to-YCbCr colour-space converter, BT.601 full-range, 8-bit fixed point.
- Sits between the DVP capture/pixel-packing stage and the 3x3 median / matrix-based luma processing stages.
- Drives their per_y, per_Cb, per_Cr and per_frame_vsync/href/clken inputs.
- Accepts RGB565 (camera native) or RGB888 input, selected by parameter.

Parameters:
- RGB565_MODE, 1: 1 = pixel input is {R5,G6,B5} on per_rgb[15:0]; 0 = RGB888 on per_rgb[23:0].
- SYNC_LATENCY, 3: pipeline depth in clk cycles; fixed at 3, not user-tunable (documents the contract).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- per_frame_vsync  in  1  input vsync.
- per_frame_href  in  1  input href.
- per_frame_clken  in  1  input pixel-valid strobe.
- per_rgb  in  24  pixel. RGB888 = {R,G,B}; in RGB565 mode only [15:0] is used and [23:16] is ignored.
- post_frame_vsync  out  1  vsync delayed 3 clk.
- post_frame_href  out  1  href delayed 3 clk.
- post_frame_clken  out  1  clken delayed 3 clk.
- post_y  out  8  luma.
- post_cb  out  8  blue-difference chroma.
- post_cr  out  8  red-difference chroma.

Behaviour:
- Clock and reset: clk; rst_n asynchronous, active-low. All pipeline registers and all outputs reset to 0 (post_cb/post_cr reset to 0, not 128).
- RGB565 expansion (combinational, before stage 1):
  - R8 = {R5, R5[4:2]}
  - G8 = {G6, G6[5:4]}
  - B8 = {B5, B5[4:2]}
- Stage 1 (clk 1): register nine unsigned 16-bit products:
  - 77R, 150G, 29B
  - 43R, 85G, 128B
  - 128R, 107G, 21B
- Stage 2 (clk 2): register 18-bit signed sums:
  - Ysum = 77R + 150G + 29B + 128
  - Cbsum = 128B − 43R − 85G + 32896
  - Crsum = 128R − 107G − 21B + 32896
  - The +128 term rounds; 32896 = 32768 + 128 (chroma offset plus rounding).
- Stage 3 (clk 3): output = sum >> 8, saturated to 0..255.
  - Shift result > 255 → 255.
  - Negative sum → 0. Unreachable for legal inputs, but required.
- Latency: post_* data corresponds to per_rgb sampled exactly 3 rising edges earlier.
- Sync signals: vsync/href/clken each pass through an unconditional 3-deep shift register, so they are aligned with data.
- Data pipeline is free-running: advances every clk regardless of per_frame_clken.
  - Data values while post_frame_clken=0 are don't-care but deterministic (computed from whatever was on per_rgb).
- No back-pressure: downstream must accept every cycle post_frame_clken=1.
- Boundary conditions:
  - Back-to-back valid pixels (clken=1 every cycle): one result per cycle, no bubbles.
  - Isolated clken pulses: each produces exactly one post_frame_clken pulse 3 cycles later.
  - vsync/href edges are preserved cycle-exactly after the 3-cycle delay.
  - Reset asserted mid-frame: all outputs go to 0 immediately (asynchronous). In-flight pixels are discarded.
  - After reset deassertion, post_frame_* stay 0 for at least 3 cycles until the shift registers refill.

Test Plan:
- Reset: hold rst_n=0 with per_frame_clken=1 and per_rgb=24'hFFFFFF → all outputs 0. Release rst_n → outputs stay 0 for the first 2 edges; first valid result (Y=255) appears after the 3rd edge.
- RGB888 primaries, RGB565_MODE=0, one pixel per cycle with clken=1:
  - FFFFFF → Y/Cb/Cr = 255/128/128
  - 000000 → 0/128/128
  - FF0000 → 77/85/255 (Cr saturated)
  - 00FF00 → 149/43/21
  - 0000FF → 29/255/107 (Cb saturated)
  - Each result arrives exactly 3 cycles after its input.
- RGB565 mode, per_rgb[23:16] randomised:
  - 16'hFFFF → 255/128/128
  - 16'hF800 → 77/85/255
  - 16'h001F → 29/255/107
  - 16'h07E0 → 149/43/21
- Sync alignment: 8-pixel href window containing a clken pattern 1,0,1,1,0,0,1,1 → post_frame_href/clken reproduce the identical pattern shifted exactly 3 cycles; vsync edge also shifted by 3.
- Mid-frame reset: assert rst_n=0 asynchronously between edges during streaming → all outputs 0 before the next edge. Release → no stale pixel from before reset is emitted.
- Random regression: 10k random RGB888 pixels with random clken → compare post_y/cb/cr against a reference model that implements the same integer formula including rounding and saturation, with zero mismatches.
